// File: rtl/dmem_bus_demux.sv
// Data-memory bus demultiplexer: routes one outstanding CPU request to target 0 or 1
// by address region, with misalignment rejection and an issue-to-response timeout.
module dmem_bus_demux #(
   parameter logic [31:0] S1_BASE = 32'h1000_0000,
   parameter logic [31:0] S1_MASK = 32'hF000_0000,
   parameter logic [7:0]  TIMEOUT = 8'd255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        req_we,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [31:0] rsp_rdata,
   output logic        s0_valid,
   input  logic        s0_ready,
   output logic [31:0] s0_addr,
   output logic [31:0] s0_wdata,
   output logic        s0_we,
   output logic [3:0]  s0_be,
   input  logic        s0_rsp_valid,
   input  logic [31:0] s0_rsp_rdata,
   output logic        s1_valid,
   input  logic        s1_ready,
   output logic [31:0] s1_addr,
   output logic [31:0] s1_wdata,
   output logic        s1_we,
   output logic [3:0]  s1_be,
   input  logic        s1_rsp_valid,
   input  logic [31:0] s1_rsp_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} state_t;

   state_t      state;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        we_q;
   logic [3:0]  be_q;
   logic        sel_q;
   logic [7:0]  cnt;

   logic        misalign;
   logic        sel_in;
   logic        tgt_ready;
   logic        tgt_rsp;
   logic [31:0] tgt_rdata;
   logic        tmo;

   always_comb begin
      req_ready = (state == IDLE);
      misalign  = ((req_be == 4'b1111) && (req_addr[1:0] != 2'b00)) ||
                  (((req_be == 4'b0011) || (req_be == 4'b1100)) && req_addr[0]);
      sel_in    = ((req_addr & S1_MASK) == S1_BASE);

      s0_valid  = (state == ISSUE) && !sel_q;
      s1_valid  = (state == ISSUE) && sel_q;
      s0_addr   = s0_valid ? addr_q  : '0;
      s0_wdata  = s0_valid ? wdata_q : '0;
      s0_we     = s0_valid ? we_q    : 1'b0;
      s0_be     = s0_valid ? be_q    : '0;
      s1_addr   = s1_valid ? addr_q  : '0;
      s1_wdata  = s1_valid ? wdata_q : '0;
      s1_we     = s1_valid ? we_q    : 1'b0;
      s1_be     = s1_valid ? be_q    : '0;

      tgt_ready = sel_q ? s1_ready     : s0_ready;
      tgt_rsp   = sel_q ? s1_rsp_valid : s0_rsp_valid;
      tgt_rdata = sel_q ? s1_rsp_rdata : s0_rsp_rdata;
      // Counter has reached (or, after a late ready, passed) the budget this cycle.
      tmo       = (cnt >= (TIMEOUT - 8'd1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         be_q      <= '0;
         sel_q     <= 1'b0;
         cnt       <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  we_q    <= req_we;
                  be_q    <= req_be;
                  sel_q   <= sel_in;
                  cnt     <= '0;
                  if (misalign) begin
                     state     <= ERR;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                  end else begin
                     state <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               cnt <= cnt + 8'd1;
               if (tgt_ready) begin
                  state <= WAIT;
               end else if (tmo) begin
                  state     <= ERR;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
               end
            end
            WAIT: begin
               // WAIT is held through the response pulse so IDLE is re-entered only after it.
               if (rsp_valid) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 8'd1;
                  if (tgt_rsp) begin
                     rsp_valid <= 1'b1;
                     rsp_rdata <= tgt_rdata;
                  end else if (tmo) begin
                     state     <= ERR;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                  end
               end
            end
            ERR: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_bus_demux.sv
// Bench for dmem_bus_demux: directed vector table, random transactions against a
// transaction-level timing model, and reset-in-flight sequences.
module tb_dmem_bus_demux;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        s0_valid, s0_ready, s0_we, s0_rsp_valid;
   logic [31:0] s0_addr, s0_wdata, s0_rsp_rdata;
   logic [3:0]  s0_be;
   logic        s1_valid, s1_ready, s1_we, s1_rsp_valid;
   logic [31:0] s1_addr, s1_wdata, s1_rsp_rdata;
   logic [3:0]  s1_be;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dmem_bus_demux #(
      .S1_BASE (32'h1000_0000),
      .S1_MASK (32'hF000_0000),
      .TIMEOUT (8'd4)
   ) dut (
      .clk (clk), .rst_n (rst_n),
      .req_valid (req_valid), .req_ready (req_ready), .req_addr (req_addr),
      .req_wdata (req_wdata), .req_we (req_we), .req_be (req_be),
      .rsp_valid (rsp_valid), .rsp_err (rsp_err), .rsp_rdata (rsp_rdata),
      .s0_valid (s0_valid), .s0_ready (s0_ready), .s0_addr (s0_addr), .s0_wdata (s0_wdata),
      .s0_we (s0_we), .s0_be (s0_be), .s0_rsp_valid (s0_rsp_valid), .s0_rsp_rdata (s0_rsp_rdata),
      .s1_valid (s1_valid), .s1_ready (s1_ready), .s1_addr (s1_addr), .s1_wdata (s1_wdata),
      .s1_we (s1_we), .s1_be (s1_be), .s1_rsp_valid (s1_rsp_valid), .s1_rsp_rdata (s1_rsp_rdata)
   );

   // r: cycles after issue before the selected target raises ready; s: cycles in WAIT before
   // it responds.  p: response-pulse cycle, vlast: last cycle with sN_valid (both relative to acceptance).
   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic [3:0]  be;
      int          r;
      int          s;
      bit          noise;
      bit          x_err;
      int          x_p;
      int          x_vlast;
      bit          x_sel;
      logic [31:0] x_rdata;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                               input logic [3:0] be, input int r, input int s, input bit noise,
                               input bit err, input int p, input int vlast, input bit sel,
                               input logic [31:0] rdata);
      vec_t v;
      v.addr = addr; v.wdata = wdata; v.we = we; v.be = be; v.r = r; v.s = s; v.noise = noise;
      v.x_err = err; v.x_p = p; v.x_vlast = vlast; v.x_sel = sel; v.x_rdata = rdata;
      return v;
   endfunction

   // Transaction-level reference: outcome and timing from the alignment, routing and
   // timeout rules, with the issue cycle counted as 1.
   function automatic vec_t predict(input vec_t v);
      vec_t o = v;
      bit   mis;
      int   c;
      mis = ((v.be == 4'hF) && (v.addr[1:0] != 2'b00)) ||
            (((v.be == 4'h3) || (v.be == 4'hC)) && v.addr[0]);
      o.x_sel = ((v.addr & 32'hF000_0000) == 32'h1000_0000);
      if (mis) begin
         o.x_err = 1; o.x_p = 1; o.x_vlast = 0;
      end else begin
         o.x_vlast = ((v.r < T - 1) ? v.r : T - 1) + 1;
         if (v.r > T - 1) begin
            o.x_err = 1; o.x_p = T + 1;
         end else if ((v.s == 0) || (v.r + 1 + v.s <= T - 1)) begin
            o.x_err = 0; o.x_p = v.r + v.s + 3;
         end else begin
            c = (v.r + 1 > T - 1) ? v.r + 1 : T - 1;
            o.x_err = 1; o.x_p = c + 2;
         end
      end
      return o;
   endfunction

   task automatic zero_tgts();
      s0_ready = 0; s0_rsp_valid = 0; s0_rsp_rdata = '0;
      s1_ready = 0; s1_rsp_valid = 0; s1_rsp_rdata = '0;
   endtask

   // Entered and left at posedge+1; the cycle of entry is the acceptance cycle.
   task automatic run_txn(input vec_t v, input string tag);
      logic        rdy, rsp, nr, nv, sv, ov, swe;
      logic [31:0] sa, sw, oa;
      logic [3:0]  sbe;
      bit          xv;
      req_valid = 1; req_addr = v.addr; req_wdata = v.wdata; req_we = v.we; req_be = v.be;
      zero_tgts();
      @(negedge clk);
      chk({tag, " accept_ready"}, req_ready, 1);
      @(posedge clk); #1;
      for (int k = 1; k <= v.x_p; k++) begin
         req_valid = 1'($urandom_range(1, 0)); req_addr = $urandom; req_wdata = $urandom;
         req_we = 1'($urandom_range(1, 0)); req_be = 4'($urandom_range(15, 0));
         rdy = (k == 1 + v.r);
         rsp = (k == 2 + v.r + v.s) || (k == 1 + v.r);
         nr  = v.noise ? 1'($urandom_range(1, 0)) : 1'b0;
         nv  = v.noise ? 1'($urandom_range(1, 0)) : 1'b0;
         if (v.x_sel) begin
            s1_ready = rdy; s1_rsp_valid = rsp; s1_rsp_rdata = v.x_rdata;
            s0_ready = nr;  s0_rsp_valid = nv;  s0_rsp_rdata = ~v.x_rdata;
         end else begin
            s0_ready = rdy; s0_rsp_valid = rsp; s0_rsp_rdata = v.x_rdata;
            s1_ready = nr;  s1_rsp_valid = nv;  s1_rsp_rdata = ~v.x_rdata;
         end
         @(negedge clk);
         if (v.x_sel) begin
            sv = s1_valid; sa = s1_addr; sw = s1_wdata; swe = s1_we; sbe = s1_be;
            ov = s0_valid; oa = s0_addr;
         end else begin
            sv = s0_valid; sa = s0_addr; sw = s0_wdata; swe = s0_we; sbe = s0_be;
            ov = s1_valid; oa = s1_addr;
         end
         xv = (k <= v.x_vlast);
         chk($sformatf("%s k%0d sel_valid", tag, k), sv, xv);
         chk($sformatf("%s k%0d other_valid", tag, k), ov, 0);
         chk($sformatf("%s k%0d other_addr", tag, k), oa, 0);
         if (xv) begin
            chk($sformatf("%s k%0d sel_addr", tag, k), sa, v.addr);
            chk($sformatf("%s k%0d sel_wdata", tag, k), sw, v.wdata);
            chk($sformatf("%s k%0d sel_we", tag, k), swe, v.we);
            chk($sformatf("%s k%0d sel_be", tag, k), sbe, v.be);
         end
         chk($sformatf("%s k%0d req_ready", tag, k), req_ready, 0);
         chk($sformatf("%s k%0d rsp_valid", tag, k), rsp_valid, (k == v.x_p));
         chk($sformatf("%s k%0d rsp_err", tag, k), rsp_err, (k == v.x_p) && v.x_err);
         chk($sformatf("%s k%0d rsp_rdata", tag, k), rsp_rdata,
             ((k == v.x_p) && !v.x_err) ? v.x_rdata : 32'h0);
         @(posedge clk); #1;
      end
      req_valid = 0;
      zero_tgts();
   endtask

   vec_t tbl[10];
   vec_t rv;

   initial begin
      rst_n = 0; req_valid = 0; req_addr = '0; req_wdata = '0; req_we = 0; req_be = '0;
      zero_tgts();

      //        addr           wdata          we    be     r  s  nz err p  vl sel rdata
      tbl[0] = mk(32'h0000_0010, 32'h0,        0, 4'hF,  0, 1, 0, 0, 4, 1, 0, 32'hDEAD_BEEF);
      tbl[1] = mk(32'h1000_0004, 32'h0000_00AA, 1, 4'h1, 1, 0, 0, 0, 4, 2, 1, 32'h1234_5678);
      tbl[2] = mk(32'h0000_0002, 32'h0,        0, 4'hF,  0, 0, 0, 1, 1, 0, 0, 32'h0);
      tbl[3] = mk(32'h0000_0100, 32'h0,        0, 4'hF,  9, 0, 0, 1, 5, 4, 0, 32'h0);
      tbl[4] = mk(32'h0000_0200, 32'h0,        0, 4'hF,  3, 0, 0, 0, 6, 4, 0, 32'hCAFE_F00D);
      tbl[5] = mk(32'h1000_0100, 32'h5555_0000, 1, 4'h3, 0, 2, 1, 0, 5, 1, 1, 32'h0BAD_CAFE);
      tbl[6] = mk(32'h0000_0031, 32'h0,        1, 4'hC,  0, 0, 0, 1, 1, 0, 0, 32'h0);
      tbl[7] = mk(32'h0000_0032, 32'h0,        0, 4'h3,  0, 0, 0, 0, 3, 1, 0, 32'h7777_0001);
      tbl[8] = mk(32'h0000_0021, 32'h0,        0, 4'h1,  2, 1, 1, 1, 5, 3, 0, 32'h0);
      tbl[9] = mk(32'h2000_0000, 32'h0,        0, 4'hF,  0, 0, 1, 0, 3, 1, 0, 32'hA5A5_5A5A);

      repeat (2) @(posedge clk);
      #1;
      chk("reset rsp_valid", rsp_valid, 0);
      chk("reset rsp_err", rsp_err, 0);
      chk("reset rsp_rdata", rsp_rdata, 0);
      chk("reset s0_valid", s0_valid, 0);
      chk("reset s1_valid", s1_valid, 0);
      rst_n = 1;
      @(negedge clk);
      chk("release req_ready", req_ready, 1);
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

      for (int i = 0; i < 150; i++) begin
         rv.addr  = $urandom;
         if ($urandom_range(1, 0) == 1) rv.addr[31:28] = 4'h1;
         rv.wdata = $urandom;
         rv.we    = 1'($urandom_range(1, 0));
         case ($urandom_range(5, 0))
            0, 1:    rv.be = 4'hF;
            2:       rv.be = 4'h3;
            3:       rv.be = 4'hC;
            default: rv.be = 4'($urandom_range(15, 0));
         endcase
         rv.r = $urandom_range(5, 0);
         rv.s = $urandom_range(4, 0);
         rv.noise = 1;
         rv.x_rdata = $urandom;
         rv = predict(rv);
         run_txn(rv, $sformatf("rnd%0d", i));
         repeat ($urandom_range(2, 0)) begin
            @(negedge clk);
            chk($sformatf("rnd%0d idle_ready", i), req_ready, 1);
            @(posedge clk); #1;
         end
      end

      // Reset pulsed while waiting for the response; a late response must be dropped.
      req_valid = 1; req_addr = 32'h0000_0040; req_wdata = '0; req_we = 0; req_be = 4'hF;
      @(negedge clk);
      chk("rstw accept_ready", req_ready, 1);
      @(posedge clk); #1;
      req_valid = 0; s0_ready = 1;
      @(negedge clk);
      chk("rstw s0_valid", s0_valid, 1);
      @(posedge clk); #1;
      s0_ready = 0;
      @(negedge clk);
      chk("rstw in_wait s0_valid", s0_valid, 0);
      #1 rst_n = 0;
      #1;
      chk("rstw rsp_valid", rsp_valid, 0);
      chk("rstw rsp_err", rsp_err, 0);
      chk("rstw rsp_rdata", rsp_rdata, 0);
      chk("rstw s0_valid", s0_valid, 0);
      chk("rstw s1_valid", s1_valid, 0);
      chk("rstw s0_addr", s0_addr, 0);
      @(posedge clk); #1;
      rst_n = 1; s0_rsp_valid = 1; s0_rsp_rdata = 32'hFEED_FACE;
      @(negedge clk);
      chk("rstw release req_ready", req_ready, 1);
      chk("rstw late rsp_valid0", rsp_valid, 0);
      @(posedge clk); #1;
      s0_rsp_valid = 0;
      @(negedge clk);
      chk("rstw late rsp_valid1", rsp_valid, 0);
      chk("rstw late rsp_rdata", rsp_rdata, 0);
      chk("rstw idle req_ready", req_ready, 1);
      @(posedge clk); #1;

      run_txn(tbl[0], "post_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
